// File: rtl/fpnew_pipe_result_buffer.sv
// fpnew_pipe_result_buffer
// Output-side result buffer between an FPU operation group's last pipeline
// stage and the result arbiter. Results are stored in a circular FIFO and
// presented in order. in_ready_o depends only on registered occupancy, which
// cuts the combinational out_ready_i path back into the pipeline.
//
// Optional feature: define FPNEW_RESULT_BUF_BYPASS_EN to enable a zero-latency
// fall-through path when the buffer is empty.
module fpnew_pipe_result_buffer #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned TagWidth  = 1,
    parameter int unsigned AuxWidth  = 1,
    parameter int unsigned Depth     = 2,
    parameter int unsigned CntWidth  = $clog2(Depth + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [DataWidth-1:0] result_i,
    input  logic [4:0]           status_i,
    input  logic [TagWidth-1:0]  tag_i,
    input  logic [AuxWidth-1:0]  aux_i,
    input  logic                 flush_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [DataWidth-1:0] result_o,
    output logic [4:0]           status_o,
    output logic [TagWidth-1:0]  tag_o,
    output logic [AuxWidth-1:0]  aux_o,
    output logic [CntWidth-1:0]  count_o,
    output logic                 busy_o
);

    localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [CntWidth-1:0] CntFull = CntWidth'(Depth);
    localparam logic [PtrWidth-1:0] PtrLast = PtrWidth'(Depth - 1);

    logic [DataWidth-1:0] result_q [Depth];
    logic [4:0]           status_q [Depth];
    logic [TagWidth-1:0]  tag_q    [Depth];
    logic [AuxWidth-1:0]  aux_q    [Depth];

    logic [CntWidth-1:0] count_q;
    logic [PtrWidth-1:0] wr_ptr_q;
    logic [PtrWidth-1:0] rd_ptr_q;

    logic empty;
    logic push;
    logic wr_en;
    logic pop;

    // Pointers wrap at Depth-1 so non-power-of-2 depths work.
    function automatic logic [PtrWidth-1:0] next_ptr(input logic [PtrWidth-1:0] ptr);
        logic [PtrWidth-1:0] nxt;
        if (ptr == PtrLast) begin
            nxt = '0;
        end else begin
            nxt = ptr + 1'b1;
        end
        return nxt;
    endfunction

    assign empty      = (count_q == '0);
    assign in_ready_o = (count_q != CntFull) & ~rst_i;
    assign push       = in_valid_i & in_ready_o & ~flush_i;
    assign count_o    = count_q;
    assign busy_o     = ~empty | in_valid_i;

`ifdef FPNEW_RESULT_BUF_BYPASS_EN
    logic bypass;
    assign bypass = empty & in_valid_i;

    // Fall-through when empty; a bypassed entry taken downstream is never stored.
    always_comb begin
        out_valid_o = (~empty | in_valid_i) & ~rst_i & ~flush_i;
        pop         = out_valid_o & out_ready_i & ~empty;
        wr_en       = push & ~(bypass & out_ready_i);
        result_o    = result_q[rd_ptr_q];
        status_o    = status_q[rd_ptr_q];
        tag_o       = tag_q[rd_ptr_q];
        aux_o       = aux_q[rd_ptr_q];
        if (bypass) begin
            result_o = result_i;
            status_o = status_i;
            tag_o    = tag_i;
            aux_o    = aux_i;
        end
    end
`else
    // Registered-only output: head entry comes straight from storage.
    always_comb begin
        out_valid_o = ~empty & ~rst_i & ~flush_i;
        pop         = out_valid_o & out_ready_i;
        wr_en       = push;
        result_o    = result_q[rd_ptr_q];
        status_o    = status_q[rd_ptr_q];
        tag_o       = tag_q[rd_ptr_q];
        aux_o       = aux_q[rd_ptr_q];
    end
`endif

    // Occupancy, pointers and storage; flush resets bookkeeping but keeps contents.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int unsigned i = 0; i < Depth; i++) begin
                result_q[i] <= '0;
                status_q[i] <= '0;
                tag_q[i]    <= '0;
                aux_q[i]    <= '0;
            end
        end else if (flush_i) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_en) begin
                result_q[wr_ptr_q] <= result_i;
                status_q[wr_ptr_q] <= status_i;
                tag_q[wr_ptr_q]    <= tag_i;
                aux_q[wr_ptr_q]    <= aux_i;
                wr_ptr_q           <= next_ptr(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= next_ptr(rd_ptr_q);
            end
            case ({wr_en, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_fpnew_pipe_result_buffer.sv
// Scoreboard bench for fpnew_pipe_result_buffer: a Depth=2 instance for the
// directed scenarios and a Depth=3 instance for randomized wrap-around traffic.
module tb_fpnew_pipe_result_buffer;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  st;
        logic [3:0]  tag;
        logic [2:0]  aux;
    } ent_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Depth=2 instance signals
    logic a_rst = 1'b1, a_iv = 1'b0, a_fl = 1'b0, a_or = 1'b0, a_zero = 1'b0;
    ent_t a_din = '0;
    logic a_ir, a_ov, a_busy;
    logic [31:0] a_res;
    logic [4:0]  a_st;
    logic [3:0]  a_tag;
    logic [2:0]  a_aux;
    logic [1:0]  a_cnt;

    // Depth=3 instance signals
    logic b_rst = 1'b1, b_iv = 1'b0, b_fl = 1'b0, b_or = 1'b0, b_zero = 1'b0;
    ent_t b_din = '0;
    logic b_ir, b_ov, b_busy;
    logic [31:0] b_res;
    logic [4:0]  b_st;
    logic [3:0]  b_tag;
    logic [2:0]  b_aux;
    logic [1:0]  b_cnt;

    fpnew_pipe_result_buffer #(.DataWidth(32), .TagWidth(4), .AuxWidth(3), .Depth(2)) u_d2 (
        .clk_i(clk), .rst_i(a_rst), .in_valid_i(a_iv), .in_ready_o(a_ir),
        .result_i(a_din.res), .status_i(a_din.st), .tag_i(a_din.tag), .aux_i(a_din.aux),
        .flush_i(a_fl), .out_valid_o(a_ov), .out_ready_i(a_or),
        .result_o(a_res), .status_o(a_st), .tag_o(a_tag), .aux_o(a_aux),
        .count_o(a_cnt), .busy_o(a_busy)
    );

    fpnew_pipe_result_buffer #(.DataWidth(32), .TagWidth(4), .AuxWidth(3), .Depth(3)) u_d3 (
        .clk_i(clk), .rst_i(b_rst), .in_valid_i(b_iv), .in_ready_o(b_ir),
        .result_i(b_din.res), .status_i(b_din.st), .tag_i(b_din.tag), .aux_i(b_din.aux),
        .flush_i(b_fl), .out_valid_o(b_ov), .out_ready_i(b_or),
        .result_o(b_res), .status_o(b_st), .tag_o(b_tag), .aux_o(b_aux),
        .count_o(b_cnt), .busy_o(b_busy)
    );

    int   total = 0;
    int   bad   = 0;
    ent_t q[2][$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: the buffer is an ordered queue of at most 'depth' entries.
    task automatic mon(input int k, input int depth, input logic rst, input logic iv,
                       input logic fl, input logic ordy, input logic ir, input logic ov,
                       input ent_t din, input ent_t dout, input logic [3:0] cnt,
                       input logic busy, input logic zero);
        int    sz;
        logic  e_ir;
        logic  e_ov;
        string p;
        sz   = q[k].size();
        p    = (k == 0) ? "d2" : "d3";
        e_ir = (sz != depth) && !rst;
`ifdef FPNEW_RESULT_BUF_BYPASS_EN
        e_ov = ((sz != 0) || iv) && !rst && !fl;
`else
        e_ov = (sz != 0) && !rst && !fl;
`endif
        chk({p, " in_ready"},  64'(ir),   64'(e_ir));
        chk({p, " out_valid"}, 64'(ov),   64'(e_ov));
        chk({p, " count"},     64'(cnt),  64'(sz));
        chk({p, " busy"},      64'(busy), 64'((sz != 0) || iv));
        if (zero) chk({p, " reset_data"}, 64'(dout), 64'(0));
        if (rst || fl) begin
            q[k].delete();
        end else begin
            if (iv && e_ir) q[k].push_back(din);
            if (e_ov) begin
                chk({p, " head_data"}, 64'(dout), 64'(q[k][0]));
                if (ordy) void'(q[k].pop_front());
            end
        end
    endtask

    // Monitor: compares both instances every cycle, away from the active edge.
    always @(negedge clk) begin
        mon(0, 2, a_rst, a_iv, a_fl, a_or, a_ir, a_ov, a_din,
            {a_res, a_st, a_tag, a_aux}, {2'b00, a_cnt}, a_busy, a_zero);
        mon(1, 3, b_rst, b_iv, b_fl, b_or, b_ir, b_ov, b_din,
            {b_res, b_st, b_tag, b_aux}, {2'b00, b_cnt}, b_busy, b_zero);
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_a(input ent_t e);
        bit acc;
        acc   = 1'b0;
        a_din = e;
        a_iv  = 1'b1;
        for (int n = 0; n < 50 && !acc; n++) begin
            @(negedge clk);
            acc = a_ir;
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            $display("FAIL d2 send_timeout actual=no_accept required=accept");
            $fatal(1, "send_a timed out");
        end
    endtask

    task automatic send_b(input ent_t e);
        bit acc;
        acc   = 1'b0;
        b_din = e;
        b_iv  = 1'b1;
        for (int n = 0; n < 60 && !acc; n++) begin
            b_or = 1'($urandom_range(0, 1));
            @(negedge clk);
            acc = b_ir;
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            $display("FAIL d3 send_timeout actual=no_accept required=accept");
            $fatal(1, "send_b timed out");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        ent_t e;
        // Power-on reset, then check reset-state outputs.
        step(2);
        a_rst = 1'b0; b_rst = 1'b0;
        a_zero = 1'b1; b_zero = 1'b1;
        step(1);
        a_zero = 1'b0; b_zero = 1'b0;

        // Mid-stream reset with two entries held.
        a_or = 1'b0;
        send_a('{res: 32'h3F80_0000, st: 5'd0, tag: 4'd1, aux: 3'd1});
        send_a('{res: 32'h4000_0000, st: 5'd1, tag: 4'd2, aux: 3'd2});
        a_iv = 1'b0; a_din = '0;
        a_rst = 1'b1;
        step(1);
        a_rst = 1'b0;
        a_zero = 1'b1;
        step(1);
        a_zero = 1'b0;

        // Back-to-back streaming with downstream always ready.
        a_or = 1'b1;
        for (int t = 0; t < 8; t++) begin
            send_a('{res: 32'h100 + 32'(t), st: 5'($urandom), tag: 4'(t), aux: 3'($urandom)});
        end
        a_iv = 1'b0;
        step(3);

        // Backpressure: third entry held upstream until a single-cycle pop.
        a_or = 1'b0;
        send_a('{res: 32'hA0, st: 5'h01, tag: 4'd0, aux: 3'd0});
        send_a('{res: 32'hA1, st: 5'h02, tag: 4'd1, aux: 3'd1});
        a_din = '{res: 32'hA2, st: 5'h04, tag: 4'd2, aux: 3'd2};
        step(2);
        a_or = 1'b1;
        step(1);
        a_or = 1'b0;
        step(1);
        a_iv = 1'b0;
        step(1);
        a_or = 1'b1;
        step(4);

        // Flush while full with push and pop requested in the same cycle.
        a_or = 1'b0;
        send_a('{res: 32'hB0, st: 5'h08, tag: 4'd3, aux: 3'd3});
        send_a('{res: 32'hB1, st: 5'h10, tag: 4'd4, aux: 3'd4});
        a_din = '{res: 32'hB2, st: 5'h1F, tag: 4'd5, aux: 3'd5};
        a_iv = 1'b1; a_fl = 1'b1; a_or = 1'b1;
        step(1);
        a_fl = 1'b0; a_iv = 1'b0; a_or = 1'b0;
        step(2);

        // Single entry into an empty buffer with downstream ready.
        a_or = 1'b1;
        a_din = '{res: 32'h0000_DEAD, st: 5'h03, tag: 4'd6, aux: 3'd6};
        a_iv = 1'b1;
        step(1);
        a_iv = 1'b0;
        step(3);
        a_or = 1'b0;

        // Depth=3 wrap-around with random gaps and random downstream readiness.
        for (int i = 0; i < 10; i++) begin
            repeat ($urandom_range(0, 1)) begin
                b_iv = 1'b0;
                b_or = 1'($urandom_range(0, 1));
                step(1);
            end
            e.res = $urandom;
            e.st  = (i == 3 || i == 7) ? 5'b10001 : 5'($urandom);
            e.tag = 4'(i);
            e.aux = 3'($urandom);
            send_b(e);
        end
        b_iv = 1'b0;
        b_or = 1'b1;
        step(8);
        b_or = 1'b0;

        step(2);
        chk("d2 drained", 64'(q[0].size()), 64'(0));
        chk("d3 drained", 64'(q[1].size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
